// File: rtl/mfp_ahb_uart_slave.sv
// mfp_ahb_uart_slave
//   AHB-Lite UART slave for the MFP AHB-Lite matrix. CPU writes are queued in a
//   TX FIFO and sent 8N1 with a programmable bit period of DIVISOR+1 HCLK cycles.
//   The slave has zero wait states: HREADY is tied high and HRESP is tied OKAY.
//   Defining MFP_UART_RX_EN adds a receiver with a one-byte holding register.
//   Without it, UART_RX is unused and the receive status/data fields read 0.
// Ports
//   HCLK, HRESETn          clock; synchronous active-low reset
//   HADDR..HWRITE          AHB-Lite slave inputs (only HADDR[3:2] decoded)
//   HRDATA, HREADY, HRESP  AHB-Lite slave response
//   SI_Endian              unused
//   UART_RX                serial input (asynchronous)
//   UART_TX                serial output, idles high
// Register map (HADDR[3:2])
//   0 DATA     wr: push byte to TX FIFO; rd: {24'b0, rx_byte}, clears rx_valid
//   1 STATUS   {rx_frame_err, rx_overrun, tx_overflow, rx_valid, tx_idle, tx_full}
//              writing 1 to bit 3/4/5 clears that sticky bit
//   2 DIVISOR  16-bit bit-period divisor; a write of 0 is stored as 1
//   3          reads 0, writes ignored
module mfp_ahb_uart_slave #(
  parameter int unsigned TX_FIFO_DEPTH   = 16,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        SI_Endian,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  // Bus address phase capture
  logic       r_wr_en, r_rd_en;
  logic [1:0] r_addr;
  logic       w_accept;
  assign w_accept = HSEL & HTRANS[1] & HREADY;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_wr_en <= w_accept & HWRITE;
      r_rd_en <= w_accept & ~HWRITE;
      r_addr  <= HADDR[3:2];
    end
  end

  logic w_wr_data, w_wr_stat, w_wr_div, w_rd_data;
  assign w_wr_data = r_wr_en && (r_addr == 2'd0);
  assign w_wr_stat = r_wr_en && (r_addr == 2'd1);
  assign w_wr_div  = r_wr_en && (r_addr == 2'd2);
  assign w_rd_data = r_rd_en && (r_addr == 2'd0);

  // TX FIFO
  logic [7:0]    r_mem [TX_FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_full, w_empty, w_push_ok, w_pop;
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = w_wr_data && !w_full;

  always_ff @(posedge HCLK) begin
    if (w_push_ok) r_mem[r_wptr] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Control registers
  logic [15:0] r_divisor;
  logic        r_tx_overflow;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_divisor     <= DEFAULT_DIVISOR;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_wr_div) r_divisor <= (HWDATA[15:0] == 16'd0) ? 16'd1 : HWDATA[15:0];
      if (w_wr_stat && HWDATA[3]) r_tx_overflow <= 1'b0;
      if (w_wr_data && w_full)    r_tx_overflow <= 1'b1;
    end
  end

  // TX FSM. UART_TX is the registered image of the current state's line level,
  // so the line lags the state by one cycle but every bit keeps its full width.
  tx_state_t   r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_idx;
  logic [7:0]  r_tx_shift;
  logic        r_tx, w_tx_bit, w_bit_end;
  assign w_bit_end = (r_tx_cnt == 16'd0);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_tx_state <= TX_IDLE;
    else          r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_pop     = 1'b0;
    w_tx_bit  = 1'b1;
    case (r_tx_state)
      TX_IDLE:  if (!w_empty) begin
                  w_pop     = 1'b1;
                  w_tx_next = TX_START;
                end
      TX_START: begin
                  w_tx_bit = 1'b0;
                  if (w_bit_end) w_tx_next = TX_DATA;
                end
      TX_DATA:  begin
                  w_tx_bit = r_tx_shift[0];
                  if (w_bit_end && r_tx_idx == 3'd7) w_tx_next = TX_STOP;
                end
      TX_STOP:  if (w_bit_end) begin
                  if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_tx_next = TX_START;
                  end else begin
                    w_tx_next = TX_IDLE;
                  end
                end
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // Baud counter counts down from the divisor latched at each bit boundary,
  // so a DIVISOR write only affects bits that start after it.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_tx       <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx <= w_tx_bit;
      if (w_pop) begin
        r_tx_shift <= r_mem[r_rptr];
        r_tx_cnt   <= r_divisor;
        r_tx_idx   <= '0;
      end else if (r_tx_state != TX_IDLE) begin
        if (w_bit_end) begin
          r_tx_cnt <= r_divisor;
          if (r_tx_state == TX_DATA) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_idx   <= r_tx_idx + 3'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt - 16'd1;
        end
      end
    end
  end

  assign UART_TX = r_tx;

  // Receiver
  logic [7:0] w_rx_byte;
  logic       w_rx_valid, w_rx_overrun, w_rx_ferr;

`ifdef MFP_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   r_rx_state, w_rx_next;
  logic        r_rx_s1, r_rx_s2, r_rx_d;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_idx;
  logic [7:0]  r_rx_shift, r_rx_byte;
  logic        r_rx_valid, r_rx_overrun, r_rx_ferr;
  logic        w_rx_tick, w_rx_good, w_rx_bad;
  assign w_rx_tick = (r_rx_cnt == 16'd0);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_good = 1'b0;
    w_rx_bad  = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_d && !r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_idx == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) begin
                  w_rx_next = RX_IDLE;
                  w_rx_good = r_rx_s2;
                  w_rx_bad  = !r_rx_s2;
                end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // In IDLE the counter is preloaded so the start bit is re-checked half a bit
  // after the edge; after that every sample is one full bit later (mid-bit).
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= UART_RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      if (r_rx_state == RX_IDLE) begin
        r_rx_cnt <= (r_divisor - 16'd1) >> 1;
        r_rx_idx <= '0;
      end else if (w_rx_tick) begin
        r_rx_cnt <= r_divisor;
        if (r_rx_state == RX_DATA) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt - 16'd1;
      end
    end
  end

  // Set wins over a same-cycle software clear.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_rx_byte    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      if (w_wr_stat && HWDATA[4]) r_rx_overrun <= 1'b0;
      if (w_wr_stat && HWDATA[5]) r_rx_ferr    <= 1'b0;
      if (w_rx_good) begin
        if (!r_rx_valid || w_rd_data) begin
          r_rx_byte  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end else if (w_rd_data) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_bad) r_rx_ferr <= 1'b1;
    end
  end

  assign w_rx_byte    = r_rx_byte;
  assign w_rx_valid   = r_rx_valid;
  assign w_rx_overrun = r_rx_overrun;
  assign w_rx_ferr    = r_rx_ferr;

  logic w_unused;
  assign w_unused = ^{HADDR[31:4], HADDR[1:0], HBURST, HMASTLOCK, HPROT, HSIZE,
                      HTRANS[0], HWDATA[31:16], SI_Endian};
`else
  assign w_rx_byte    = '0;
  assign w_rx_valid   = 1'b0;
  assign w_rx_overrun = 1'b0;
  assign w_rx_ferr    = 1'b0;

  logic w_unused;
  assign w_unused = ^{HADDR[31:4], HADDR[1:0], HBURST, HMASTLOCK, HPROT, HSIZE,
                      HTRANS[0], HWDATA[31:16], SI_Endian, UART_RX};
`endif

  // Read data (combinational in the data phase)
  logic [5:0] w_status;
  assign w_status = {w_rx_ferr, w_rx_overrun, r_tx_overflow, w_rx_valid,
                     w_empty && (r_tx_state == TX_IDLE), w_full};

  always_comb begin
    HRDATA = '0;
    if (r_rd_en) begin
      case (r_addr)
        2'd0:    HRDATA = {24'd0, w_rx_byte};
        2'd1:    HRDATA = {26'd0, w_status};
        2'd2:    HRDATA = {16'd0, r_divisor};
        default: HRDATA = '0;
      endcase
    end
  end

endmodule
